// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage constants, state type and helpers.
package cpu_pkg;
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM = 2'd1;
  localparam logic [1:0] PC_REG = 2'd2;
  typedef enum logic [1:0] {RUN = 2'd0, REQ = 2'd1, FILL = 2'd2} fetch_state_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return v + {31'd0, ~&v};
  endfunction
endpackage

// File: rtl/fetch_mem_if.sv
// fetch_mem_if: line refill handshake plus cache write port of the fetch stage.
interface fetch_mem_if #(parameter int LINE_WORDS = 4, parameter int ADDR_W = 32);
  localparam int IDX_W = $clog2(LINE_WORDS);
  logic req;
  logic [ADDR_W-1:0] addr;
  logic ack;
  logic valid;
  logic [31:0] rdata;
  logic fill_we;
  logic [IDX_W-1:0] fill_idx;
  logic [31:0] fill_data;
  modport master(output req, addr, fill_we, fill_idx, fill_data, input ack, valid, rdata);
  modport slave(input req, addr, fill_we, fill_idx, fill_data, output ack, valid, rdata);
endinterface

// File: rtl/line_fill_counter.sv
// line_fill_counter: refill beat index with clear, increment and last-beat flag.
module line_fill_counter #(parameter int W = 2) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic [W-1:0] cnt,
  output logic last
);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  assign last = &cnt;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencing from redirects, load-use hazards and icache misses.
module fetch_ctrl import cpu_pkg::*; #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic icache_hit_i,
  input  logic redirect_i,
  input  logic [1:0] redirect_src_i,
  input  logic load_use_i,
  output logic PCEn_o,
  output logic [1:0] PCsrc_o,
  output logic IF_ID_En_o,
  output logic flush_o,
  output logic ID_EX_flush_o,
  fetch_mem_if.master mem,
  output logic [31:0] miss_cnt_o
);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF = IDX_W + 2;
  fetch_state_t state;
  logic [ADDR_W-1:0] miss_addr;
  logic [IDX_W-1:0] cnt;
  logic last, miss, hold, go;
  line_fill_counter #(.W(IDX_W)) u_cnt (
    .clk(clk_i),
    .rst(rst_i),
    .clr(state == REQ && mem.ack),
    .inc(state == FILL && mem.valid),
    .cnt(cnt),
    .last(last)
  );
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= RUN;
      miss_addr <= '0;
      miss_cnt_o <= '0;
    end else if (miss) begin
      state <= REQ;
      miss_addr <= {pc_i[ADDR_W-1:OFF], {OFF{1'b0}}};
      miss_cnt_o <= sat_inc(miss_cnt_o);
    end else if (state == REQ && mem.ack) state <= FILL;
    else if (state == FILL && mem.valid && last) state <= RUN;
  // A redirect wins everywhere; the refill in flight keeps running underneath it.
  always_comb begin
    miss = state == RUN && !redirect_i && !icache_hit_i;
    hold = miss || state != RUN;
    go = !rst_i && (redirect_i || !(hold || load_use_i));
    PCEn_o = go;
    IF_ID_En_o = go;
    PCsrc_o = (!rst_i && redirect_i) ? redirect_src_i : PC_PLUS4;
    flush_o = rst_i || redirect_i || (hold && !load_use_i);
    ID_EX_flush_o = rst_i || redirect_i || load_use_i;
    mem.req = !rst_i && state == REQ;
    mem.addr = miss_addr;
    mem.fill_we = !rst_i && state == FILL && mem.valid;
    mem.fill_idx = cnt;
    mem.fill_data = mem.rdata;
  end
endmodule
